// File: rtl/mac_test_pkg.sv
// Shared constants, TX state encoding and beat-content helpers for the
// loopback traffic generator and its RX checker.
package mac_test_pkg;

    localparam int          MAX_DW   = 512;
    localparam logic [15:0] MAGIC    = 16'hA5C3;
    localparam logic [31:0] LANE_XOR = 32'h5A5A_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_RDY,
        ST_GAP,
        ST_SEND,
        ST_FIN
    } tx_state_t;

    // Payload beat k of frame s; callers truncate to their own data width.
    function automatic logic [MAX_DW-1:0] beat_pattern(input logic [15:0] s,
                                                      input logic [15:0] k,
                                                      input int          dw);
        logic [MAX_DW-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_DW / 32; i++) begin
            if (i < dw / 32) v[i*32 +: 32] = {s, k} ^ LANE_XOR;
        end
        return v;
    endfunction

    function automatic logic [MAX_DW-1:0] header_beat(input logic [15:0] s,
                                                     input logic [15:0] len);
        logic [MAX_DW-1:0] v;
        v        = '0;
        v[15:0]  = MAGIC;
        v[31:16] = s;
        v[47:32] = len;
        return v;
    endfunction

endpackage

// File: rtl/mac_frame_checker.sv
// RX side of the loopback tester: validates each returning frame against the
// self-describing format and tracks good/bad/sequence-error counts.
import mac_test_pkg::*;

module mac_frame_checker #(
    parameter int DATA_WIDTH = 64,
    parameter int LEN_MIN    = 2,
    parameter int LEN_MAX    = 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_clear,
    input  logic [DATA_WIDTH-1:0]   i_tdata,
    input  logic [DATA_WIDTH/8-1:0] i_tkeep,
    input  logic                    i_tvalid,
    input  logic                    i_tlast,
    input  logic                    i_tuser,
    output logic [CNT_WIDTH-1:0]    o_good,
    output logic [CNT_WIDTH-1:0]    o_bad,
    output logic [CNT_WIDTH-1:0]    o_seq_errs
);

    logic [15:0]           r_beat;
    logic [15:0]           r_s;
    logic [15:0]           r_len;
    logic                  r_err;
    logic                  r_resync;
    logic [15:0]           r_exp_seq;
    logic [CNT_WIDTH-1:0]  r_good;
    logic [CNT_WIDTH-1:0]  r_bad;
    logic [CNT_WIDTH-1:0]  r_seq_errs;

    logic                  w_hdr;
    logic [15:0]           w_s;
    logic [15:0]           w_len;
    logic [DATA_WIDTH-1:0] w_expect;
    logic [DATA_WIDTH-1:0] w_mask;
    logic                  w_mismatch;
    logic                  w_last_idx;
    logic                  w_frame_err;
    logic                  w_active;
    logic                  w_close_good;
    logic                  w_close_bad;
    logic                  w_seq_err;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Header fields are taken from the live beat so a one-beat frame is judged correctly.
    always_comb begin
        w_hdr = (r_beat == 16'd0);
        w_s   = w_hdr ? i_tdata[31:16] : r_s;
        w_len = w_hdr ? i_tdata[47:32] : r_len;
        if (w_hdr) w_expect = DATA_WIDTH'(header_beat(w_s, w_len));
        else       w_expect = DATA_WIDTH'(beat_pattern(r_s, r_beat, DATA_WIDTH));
        w_mask = '0;
        for (int b = 0; b < DATA_WIDTH / 8; b++) w_mask[b*8 +: 8] = {8{i_tkeep[b]}};
        w_mismatch = (|((i_tdata ^ w_expect) & w_mask))
                   || (w_hdr && ((w_len < 16'(LEN_MIN)) || (w_len > 16'(LEN_MAX))));
        w_last_idx   = (r_beat == w_len - 16'd1);
        w_frame_err  = r_err || w_mismatch;
        w_active     = i_tvalid && !r_resync;
        w_seq_err    = w_active && w_hdr && (w_s != r_exp_seq);
        w_close_good = w_active && i_tlast && w_last_idx && !w_frame_err && !i_tuser;
        w_close_bad  = w_active && ((i_tlast && !(w_last_idx && !w_frame_err && !i_tuser))
                                    || (!i_tlast && w_last_idx));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_beat    <= '0;
            r_s       <= '0;
            r_len     <= 16'(LEN_MIN);
            r_err     <= 1'b0;
            r_resync  <= 1'b0;
            r_exp_seq <= '0;
        end else if (i_tvalid) begin
            if (r_resync) begin
                if (i_tlast) r_resync <= 1'b0;
            end else begin
                if (w_hdr) begin
                    r_s       <= w_s;
                    r_len     <= w_len;
                    r_exp_seq <= w_s + 16'd1;
                end
                if (i_tlast || w_last_idx) begin
                    r_beat   <= '0;
                    r_err    <= 1'b0;
                    r_resync <= !i_tlast;
                end else begin
                    r_beat <= r_beat + 16'd1;
                    r_err  <= w_frame_err;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_good     <= '0;
            r_bad      <= '0;
            r_seq_errs <= '0;
        end else if (i_clear) begin
            r_good     <= '0;
            r_bad      <= '0;
            r_seq_errs <= '0;
        end else begin
            if (w_close_good) r_good     <= sat_inc(r_good);
            if (w_close_bad)  r_bad      <= sat_inc(r_bad);
            if (w_seq_err)    r_seq_errs <= sat_inc(r_seq_errs);
        end
    end

    assign o_good     = r_good;
    assign o_bad      = r_bad;
    assign o_seq_errs = r_seq_errs;

endmodule

// File: rtl/mac_loopback_tester.sv
// AXI-Stream loopback traffic generator: sends numbered frames once the MAC is
// ready, checks what comes back and reports pass/fail status.
import mac_test_pkg::*;

module mac_loopback_tester #(
    parameter int DATA_WIDTH     = 64,
    parameter int NUM_FRAMES     = 16,
    parameter int LEN_MIN        = 2,
    parameter int LEN_MAX        = 8,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                    sys_clk,
    input  logic                    sys_reset_n,
    input  logic                    mac_ready,
    input  logic                    start,
    output logic [DATA_WIDTH-1:0]   tx_tdata,
    output logic [DATA_WIDTH/8-1:0] tx_tkeep,
    output logic                    tx_tvalid,
    output logic                    tx_tlast,
    input  logic                    tx_tready,
    input  logic [DATA_WIDTH-1:0]   rx_tdata,
    input  logic [DATA_WIDTH/8-1:0] rx_tkeep,
    input  logic                    rx_tvalid,
    input  logic                    rx_tlast,
    input  logic                    rx_tuser,
    output logic [CNT_WIDTH-1:0]    tx_frames,
    output logic [CNT_WIDTH-1:0]    rx_good,
    output logic [CNT_WIDTH-1:0]    rx_bad,
    output logic [CNT_WIDTH-1:0]    seq_errs,
    output logic                    timeout,
    output logic                    busy,
    output logic                    done,
    output logic                    pass
);

    tx_state_t             r_state;
    logic [15:0]           r_seq;
    logic [15:0]           r_len;
    logic [15:0]           r_beat;
    logic [31:0]           r_gap_cnt;
    logic [31:0]           r_to_cnt;
    logic [CNT_WIDTH-1:0]  r_tx_frames;
    logic [CNT_WIDTH-1:0]  r_outstanding;
    logic                  r_timeout;
    logic                  r_done;
    logic                  r_pass;

    tx_state_t             w_state_nxt;
    logic                  w_clear;
    logic                  w_fin_exit;
    logic                  w_last_beat;
    logic                  w_tx_acc;
    logic                  w_tx_last_acc;
    logic                  w_rx_last;
    logic [DATA_WIDTH-1:0] w_tx_data;
    logic [CNT_WIDTH-1:0]  w_rx_good;
    logic [CNT_WIDTH-1:0]  w_rx_bad;
    logic [CNT_WIDTH-1:0]  w_seq_errs;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign w_last_beat   = (r_beat == r_len - 16'd1);
    assign w_tx_acc      = tx_tvalid && tx_tready;
    assign w_tx_last_acc = w_tx_acc && w_last_beat;
    assign w_rx_last     = rx_tvalid && rx_tlast;

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_fin_exit  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_clear     = 1'b1;
                    w_state_nxt = ST_WAIT_RDY;
                end
            end
            ST_WAIT_RDY: begin
                if (mac_ready) w_state_nxt = (GAP_CYCLES == 0) ? ST_SEND : ST_GAP;
            end
            ST_GAP: begin
                if (r_gap_cnt == 32'(GAP_CYCLES - 1)) w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                // A frame in flight always completes; mac_ready only gates the next one.
                if (tx_tready && w_last_beat) begin
                    if ((NUM_FRAMES != 0) && (r_tx_frames == CNT_WIDTH'(NUM_FRAMES - 1)))
                        w_state_nxt = ST_FIN;
                    else if (!mac_ready)
                        w_state_nxt = ST_WAIT_RDY;
                    else
                        w_state_nxt = (GAP_CYCLES == 0) ? ST_SEND : ST_GAP;
                end
            end
            ST_FIN: begin
                if ((r_outstanding == '0) || r_timeout) begin
                    w_fin_exit  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) r_state <= ST_IDLE;
        else              r_state <= w_state_nxt;
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n)           r_gap_cnt <= '0;
        else if (r_state == ST_GAP) r_gap_cnt <= r_gap_cnt + 32'd1;
        else                        r_gap_cnt <= '0;
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_seq  <= '0;
            r_len  <= 16'(LEN_MIN);
            r_beat <= '0;
        end else if (w_tx_acc) begin
            if (w_last_beat) begin
                r_beat <= '0;
                r_seq  <= r_seq + 16'd1;
                r_len  <= (r_len == 16'(LEN_MAX)) ? 16'(LEN_MIN) : r_len + 16'd1;
            end else begin
                r_beat <= r_beat + 16'd1;
            end
        end
    end

    always_comb begin
        if (r_beat == 16'd0) w_tx_data = DATA_WIDTH'(header_beat(r_seq, r_len));
        else                 w_tx_data = DATA_WIDTH'(beat_pattern(r_seq, r_beat, DATA_WIDTH));
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n)       r_tx_frames <= '0;
        else if (w_clear)       r_tx_frames <= '0;
        else if (w_tx_last_acc) r_tx_frames <= sat_inc(r_tx_frames);
    end

    // Simultaneous TX and RX frame ends cancel out.
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_outstanding <= '0;
        end else if (w_tx_last_acc && !w_rx_last) begin
            r_outstanding <= sat_inc(r_outstanding);
        end else if (w_rx_last && !w_tx_last_acc && (r_outstanding != '0)) begin
            r_outstanding <= r_outstanding - 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else if (w_clear) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else if (rx_tvalid || (r_outstanding == '0)) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
            r_timeout <= 1'b1;
        end else begin
            r_to_cnt <= r_to_cnt + 32'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_done <= 1'b0;
            r_pass <= 1'b0;
        end else if (w_clear) begin
            r_done <= 1'b0;
            r_pass <= 1'b0;
        end else if (w_fin_exit) begin
            r_done <= 1'b1;
            r_pass <= (w_rx_bad == '0) && (w_seq_errs == '0) && !r_timeout
                      && (w_rx_good == CNT_WIDTH'(NUM_FRAMES));
        end
    end

    mac_frame_checker #(
        .DATA_WIDTH (DATA_WIDTH),
        .LEN_MIN    (LEN_MIN),
        .LEN_MAX    (LEN_MAX),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_checker (
        .i_clk      (sys_clk),
        .i_rst_n    (sys_reset_n),
        .i_clear    (w_clear),
        .i_tdata    (rx_tdata),
        .i_tkeep    (rx_tkeep),
        .i_tvalid   (rx_tvalid),
        .i_tlast    (rx_tlast),
        .i_tuser    (rx_tuser),
        .o_good     (w_rx_good),
        .o_bad      (w_rx_bad),
        .o_seq_errs (w_seq_errs)
    );

    // Outputs are forced to zero outside SEND so reset leaves every port at 0.
    assign tx_tvalid = (r_state == ST_SEND);
    assign tx_tlast  = tx_tvalid && w_last_beat;
    assign tx_tdata  = tx_tvalid ? w_tx_data : '0;
    assign tx_tkeep  = {(DATA_WIDTH/8){sys_reset_n}};
    assign tx_frames = r_tx_frames;
    assign rx_good   = w_rx_good;
    assign rx_bad    = w_rx_bad;
    assign seq_errs  = w_seq_errs;
    assign timeout   = r_timeout;
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign pass      = r_pass;

endmodule

// File: tb/tb_mac_loopback_tester.sv
// Wire-loopback bench for mac_loopback_tester with fault injection in the
// return path and an independent model of the transmitted frame stream.
module tb_mac_loopback_tester;

    localparam int DW   = 64;
    localparam int NF   = 16;
    localparam int LMIN = 2;
    localparam int LMAX = 8;

    logic          sys_clk = 1'b0;
    logic          sys_reset_n = 1'b1;
    logic          mac_ready = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] tx_tdata;
    logic [7:0]    tx_tkeep;
    logic          tx_tvalid, tx_tlast;
    logic          tx_tready = 1'b1;
    logic [DW-1:0] rx_tdata;
    logic [7:0]    rx_tkeep;
    logic          rx_tvalid, rx_tlast, rx_tuser;
    logic [31:0]   tx_frames, rx_good, rx_bad, seq_errs;
    logic          timeout, busy, done, pass;

    int n_checks = 0;
    int n_errors = 0;
    int bp_pct = 100;
    int fault_flip = -1;
    int fault_drop = -1;
    int tb_fr, tb_bt;

    always #5 sys_clk = ~sys_clk;

    mac_loopback_tester dut (
        .sys_clk     (sys_clk),
        .sys_reset_n (sys_reset_n),
        .mac_ready   (mac_ready),
        .start       (start),
        .tx_tdata    (tx_tdata),
        .tx_tkeep    (tx_tkeep),
        .tx_tvalid   (tx_tvalid),
        .tx_tlast    (tx_tlast),
        .tx_tready   (tx_tready),
        .rx_tdata    (rx_tdata),
        .rx_tkeep    (rx_tkeep),
        .rx_tvalid   (rx_tvalid),
        .rx_tlast    (rx_tlast),
        .rx_tuser    (rx_tuser),
        .tx_frames   (tx_frames),
        .rx_good     (rx_good),
        .rx_bad      (rx_bad),
        .seq_errs    (seq_errs),
        .timeout     (timeout),
        .busy        (busy),
        .done        (done),
        .pass        (pass)
    );

    // Loopback path: only accepted TX beats reappear; one frame may be dropped or corrupted.
    logic w_acc;
    assign w_acc     = tx_tvalid && tx_tready;
    assign rx_tvalid = w_acc && (tb_fr != fault_drop);
    assign rx_tdata  = tx_tdata ^ (((tb_fr == fault_flip) && (tb_bt == 1)) ? (64'd1 << 40) : 64'd0);
    assign rx_tkeep  = tx_tkeep;
    assign rx_tlast  = tx_tlast;
    assign rx_tuser  = 1'b0;

    always @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            tb_fr <= 0;
            tb_bt <= 0;
        end else if (w_acc) begin
            if (tx_tlast) begin
                tb_fr <= tb_fr + 1;
                tb_bt <= 0;
            end else begin
                tb_bt <= tb_bt + 1;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] exp_beat(input int s, input int k, input int len);
        logic [15:0] s16, k16, l16;
        logic [31:0] lane;
        s16 = s[15:0];
        k16 = k[15:0];
        l16 = len[15:0];
        lane = {s16, k16} ^ 32'h5A5A_0000;
        if (k == 0) return {16'h0000, l16, s16, 16'hA5C3};
        return {lane, lane};
    endfunction

    // Expected end-of-run status for a run with at most one corrupted or one dropped frame.
    function automatic void run_model(input int flip, input int drop,
                                      output int g, output int b, output int sq,
                                      output bit to, output bit ps);
        b  = (flip >= 0) ? 1 : 0;
        g  = NF - b - ((drop >= 0) ? 1 : 0);
        sq = ((drop >= 0) && (drop < NF - 1)) ? 1 : 0;
        to = (drop >= 0);
        ps = (g == NF) && (b == 0) && (sq == 0) && !to;
    endfunction

    // TX scoreboard: frame s has length LMIN + (s mod span), sequence restarts at reset.
    initial begin
        int m_seq, m_len, m_beat;
        logic stall_prev;
        logic [63:0] data_prev;
        m_seq = 0; m_len = LMIN; m_beat = 0; stall_prev = 1'b0; data_prev = '0;
        forever begin
            @(negedge sys_clk);
            if (!sys_reset_n) begin
                m_seq = 0; m_len = LMIN; m_beat = 0; stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("stall_valid_held", 64'(tx_tvalid), 64'd1);
                    check("stall_data_stable", tx_tdata, data_prev);
                end
                if (tx_tvalid) begin
                    check("tx_data", tx_tdata, exp_beat(m_seq, m_beat, m_len));
                    check("tx_last", 64'(tx_tlast), 64'(m_beat == m_len - 1));
                    check("tx_keep", 64'(tx_tkeep), 64'hFF);
                    if (tx_tready) begin
                        if (m_beat == m_len - 1) begin
                            m_beat = 0;
                            m_seq  = (m_seq + 1) & 16'hFFFF;
                            m_len  = (m_len == LMAX) ? LMIN : m_len + 1;
                        end else begin
                            m_beat++;
                        end
                    end
                end
                stall_prev = tx_tvalid && !tx_tready;
                data_prev  = tx_tdata;
            end
        end
    end

    initial begin
        forever begin
            @(posedge sys_clk);
            #1;
            tx_tready = ($urandom_range(0, 99) < bp_pct);
        end
    end

    task automatic do_reset();
        @(negedge sys_clk);
        sys_reset_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_reset_n = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic pulse_start();
        @(posedge sys_clk);
        #1 start = 1'b1;
        @(posedge sys_clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 20000; i++) begin
            @(negedge sys_clk);
            if (done) break;
        end
        check($sformatf("%s_done", name), 64'(done), 64'd1);
    endtask

    task automatic check_run(input string name, input int g, input int b, input int sq,
                             input bit to, input bit ps);
        check($sformatf("%s_tx_frames", name), 64'(tx_frames), 64'(NF));
        check($sformatf("%s_rx_good", name), 64'(rx_good), 64'(g));
        check($sformatf("%s_rx_bad", name), 64'(rx_bad), 64'(b));
        check($sformatf("%s_seq_errs", name), 64'(seq_errs), 64'(sq));
        check($sformatf("%s_timeout", name), 64'(timeout), 64'(to));
        check($sformatf("%s_pass", name), 64'(pass), 64'(ps));
        check($sformatf("%s_busy", name), 64'(busy), 64'd0);
    endtask

    task automatic check_all_zero(input string name);
        check($sformatf("%s_tx_tdata", name), tx_tdata, 64'd0);
        check($sformatf("%s_tx_ctl", name), {62'd0, tx_tvalid, tx_tlast}, 64'd0);
        check($sformatf("%s_tx_tkeep", name), 64'(tx_tkeep), 64'd0);
        check($sformatf("%s_counts", name), 64'(tx_frames | rx_good | rx_bad | seq_errs), 64'd0);
        check($sformatf("%s_status", name), {60'd0, timeout, busy, done, pass}, 64'd0);
    endtask

    task automatic run_scenario(input string name, input int bp, input int flip, input int drop,
                                input int g, input int b, input int sq, input bit to, input bit ps);
        do_reset();
        bp_pct = bp;
        fault_flip = flip;
        fault_drop = drop;
        mac_ready = 1'b1;
        pulse_start();
        wait_done(name);
        check_run(name, g, b, sq, to, ps);
    endtask

    typedef struct {
        string name;
        int    bp;
        int    flip;
        int    drop;
        int    g;
        int    b;
        int    sq;
        bit    to;
        bit    ps;
    } vec_t;

    vec_t vecs[5];

    initial begin
        bit saw;
        int rg, rb, rsq;
        bit rto, rps;

        vecs[0] = '{"clean",      100, -1, -1, 16, 0, 0, 1'b0, 1'b1};
        vecs[1] = '{"backpress",   50, -1, -1, 16, 0, 0, 1'b0, 1'b1};
        vecs[2] = '{"flip_f3",    100,  3, -1, 15, 1, 0, 1'b0, 1'b0};
        vecs[3] = '{"drop_f5",     50, -1,  5, 15, 0, 1, 1'b1, 1'b0};
        vecs[4] = '{"drop_last",  100, -1, 15, 15, 0, 0, 1'b1, 1'b0};

        #2 sys_reset_n = 1'b0;
        #3;
        check_all_zero("reset");
        do_reset();

        foreach (vecs[i])
            run_scenario(vecs[i].name, vecs[i].bp, vecs[i].flip, vecs[i].drop,
                         vecs[i].g, vecs[i].b, vecs[i].sq, vecs[i].to, vecs[i].ps);

        for (int r = 0; r < 3; r++) begin
            int kind, fr, bp, fl, dr;
            kind = $urandom_range(0, 2);
            fr   = $urandom_range(0, NF - 1);
            bp   = $urandom_range(30, 100);
            fl   = (kind == 1) ? fr : -1;
            dr   = (kind == 2) ? fr : -1;
            run_model(fl, dr, rg, rb, rsq, rto, rps);
            run_scenario($sformatf("rand%0d", r), bp, fl, dr, rg, rb, rsq, rto, rps);
        end

        // mac_ready held low after start, then dropped in the middle of frame 4.
        do_reset();
        bp_pct = 100; fault_flip = -1; fault_drop = -1;
        mac_ready = 1'b0;
        pulse_start();
        saw = 1'b0;
        repeat (100) begin
            @(negedge sys_clk);
            if (tx_tvalid) saw = 1'b1;
        end
        check("no_tx_before_ready", 64'(saw), 64'd0);
        check("busy_waiting_ready", 64'(busy), 64'd1);
        mac_ready = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge sys_clk);
            if (tb_fr == 4 && tb_bt == 1 && tx_tvalid) break;
        end
        check("reach_frame4_beat1", 64'(tb_bt), 64'd1);
        mac_ready = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge sys_clk);
            if (tb_fr == 5) break;
        end
        check("midframe_completes", 64'(tb_fr), 64'd5);
        saw = 1'b0;
        repeat (50) begin
            @(negedge sys_clk);
            if (tx_tvalid) saw = 1'b1;
        end
        check("tx_paused", 64'(saw), 64'd0);
        pulse_start();
        mac_ready = 1'b1;
        wait_done("ready_toggle");
        check_run("ready_toggle", NF, 0, 0, 1'b0, 1'b1);

        // Reset in the middle of frame 7, then a fresh run.
        do_reset();
        bp_pct = 100; fault_flip = -1; fault_drop = -1;
        mac_ready = 1'b1;
        pulse_start();
        for (int i = 0; i < 2000; i++) begin
            @(negedge sys_clk);
            if (tb_fr == 7 && tx_tvalid) break;
        end
        check("reach_frame7", 64'(tb_fr), 64'd7);
        sys_reset_n = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        repeat (2) @(negedge sys_clk);
        sys_reset_n = 1'b1;
        @(negedge sys_clk);
        pulse_start();
        wait_done("after_reset");
        check_run("after_reset", NF, 0, 0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mac_loopback_tester.md
Name: mac_loopback_tester

Overview:
- Synthesisable AXI-Stream traffic generator and loopback checker. It sits between the user side of the QSFP MAC and the fabric.
- Once mac_ready is high, it sends numbered, self-describing frames out the TX stream. It checks the frames that come back on the RX stream (GT or MAC loopback) and keeps pass/fail counters.
- This replaces passive lock-waiting benches: the test result is visible on hardware and in simulation.

Parameters:
- DATA_WIDTH, 64, AXIS tdata width; multiple of 32, minimum 64.
- NUM_FRAMES, 16, frames to send per run; 0 = continuous.
- LEN_MIN, 2, minimum frame length in beats (header included); minimum 2.
- LEN_MAX, 8, maximum frame length in beats; LEN_MAX >= LEN_MIN, maximum 65535.
- GAP_CYCLES, 4, idle cycles between frames; 0 allowed.
- TIMEOUT_CYCLES, 4096, RX inactivity limit while frames are outstanding.
- CNT_WIDTH, 32, width of the status counters.

Ports:
- sys_clk, in, 1, single clock for all logic.
- sys_reset_n, in, 1, asynchronous active-low reset.
- mac_ready, in, 1, MAC link usable; level-sensitive.
- start, in, 1, one-cycle pulse; begins a run.
- tx_tdata, out, DATA_WIDTH, TX stream data.
- tx_tkeep, out, DATA_WIDTH/8, TX byte enables; always all ones.
- tx_tvalid, out, 1, TX valid.
- tx_tlast, out, 1, TX end of frame.
- tx_tready, in, 1, TX ready from the MAC.
- rx_tdata, in, DATA_WIDTH, RX stream data.
- rx_tkeep, in, DATA_WIDTH/8, RX byte enables.
- rx_tvalid, in, 1, RX valid.
- rx_tlast, in, 1, RX end of frame.
- rx_tuser, in, 1, MAC bad-frame flag, sampled on the tlast beat.
- tx_frames, out, CNT_WIDTH, frames fully sent.
- rx_good, out, CNT_WIDTH, frames received intact.
- rx_bad, out, CNT_WIDTH, frames received with an error.
- seq_errs, out, CNT_WIDTH, sequence gaps or reorders.
- timeout, out, 1, sticky; RX stalled.
- busy, out, 1, run in progress.
- done, out, 1, sticky; run complete.
- pass, out, 1, valid only when done=1.

Behaviour:
- Reset: all outputs are 0. Internal registers reset as follows: seq=0, len=LEN_MIN, expected_seq=0, outstanding=0.
- Frame format for sequence number s and length L:
  - Beat 0 (header): [15:0]=16'hA5C3, [31:16]=s[15:0], [47:32]=L, remaining bits 0.
  - Beat k, for 1<=k<L: every 32-bit lane = {s[15:0], k[15:0]} XOR 32'h5A5A_0000.
  - tlast is asserted on beat L-1 only.
- Frame length: starts at LEN_MIN, increments by 1 per frame, wraps from LEN_MAX back to LEN_MIN.
- TX state machine, states IDLE, WAIT_RDY, GAP, SEND, FIN:
  - IDLE: on start, clear all counters, timeout, done and pass, then go to WAIT_RDY; busy=1.
  - WAIT_RDY: go to GAP when mac_ready=1.
  - GAP: count GAP_CYCLES cycles, then go to SEND.
  - SEND: tvalid=1. A beat advances only when tvalid&&tready. Data stays stable while stalled.
  - At the accepted tlast beat: tx_frames+1, seq+1, length advances. Go to FIN if NUM_FRAMES frames have been sent, otherwise go to GAP (or to WAIT_RDY if mac_ready=0).
  - mac_ready dropping mid-frame does not abort the frame; the frame completes.
  - FIN: wait until outstanding==0 or timeout=1. Then done=1, busy=0, pass=(rx_bad==0 && seq_errs==0 && !timeout && rx_good==NUM_FRAMES). Return to IDLE; done stays high until the next start.
  - start while busy is ignored.
- RX checker (always receiving, tready implied):
  - Tracks beat index. Compares the header magic, the length field, and each payload beat against the expected value for the received s, masked by rx_tkeep.
  - A frame is bad if any of these holds: a compare mismatch; tlast arrives at a beat index other than L-1; tlast is missing at L-1 (the frame is closed as bad at that beat and the checker resyncs on the next tlast); rx_tuser=1 at tlast.
  - Good frame: rx_good+1. Bad frame: rx_bad+1.
  - If header s != expected_seq: seq_errs+1. Then expected_seq = s+1 (16-bit wrap).
  - outstanding increments at TX tlast and decrements at RX tlast, saturating at 0. When both happen in the same cycle, outstanding is unchanged.
- Timeout:
  - The counter runs while outstanding>0 && rx_tvalid==0 and clears on any rx_tvalid.
  - Reaching TIMEOUT_CYCLES sets timeout=1 (sticky).
- Counters saturate at all-ones.
- Continuous mode (NUM_FRAMES=0): the block never enters FIN, so done stays 0.
- Reset asserted mid-operation: everything returns to reset values immediately. There is no frame completion.

Decomposition:
- Shared package mac_test_pkg holds:
  - the magic constant 16'hA5C3 and the XOR mask 32'h5A5A_0000;
  - the TX state enumeration;
  - the function beat_pattern(s, k, DATA_WIDTH), used by both the generator and the checker.
- One sub-module, mac_frame_checker: the RX compare, RX counters and sequence tracking. The top level keeps the TX FSM, the outstanding counter and the timeout.

Test Plan:
- Direct tx→rx wire loopback, NUM_FRAMES=16, LEN 2..8, tready=1 → tx_frames=16, rx_good=16, rx_bad=0, seq_errs=0, done=1, pass=1.
- Random tready backpressure at 50% → same counts as the first scenario. tx_tdata is stable during every stalled cycle.
- Flip bit 40 of payload beat 1 in frame 3 → rx_bad=1, rx_good=15, pass=0.
- Drop frame 5 in the loopback path → seq_errs=1, rx_good=15, timeout=1 after TIMEOUT_CYCLES, done=1, pass=0.
- mac_ready low at start, raised after 100 cycles → no tx_tvalid before it rises. mac_ready deasserted mid-frame → that frame completes and TX then pauses.
- Assert sys_reset_n low during frame 7 → every output reads 0 in the same cycle. A new start then gives a clean run with pass=1.
